// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if
//   Bundles the request, response and multiplier-cell signals of the
//   multiply sequencer.
//
//   Handshake rule for both req_* and resp_*: a transfer happens on a
//   rising clk edge where valid and ready are both 1. The producer holds
//   valid and its payload stable until that edge. The consumer may raise
//   or drop ready freely.
//
//   Signals:
//     req_valid/req_ready/req_op/req_a/req_b : issue logic -> sequencer
//     resp_valid/resp_ready/resp_data        : sequencer -> issue logic
//     mul_a/mul_b/mul_en                     : sequencer -> multiplier cell
//     mul_p                                  : multiplier cell -> sequencer
//
//   Modports:
//     slave  : the sequencer side
//     master : the environment side (issue logic plus the multiplier cell)
interface mul_seq_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_en;
  logic [31:0] mul_p;

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready, mul_p,
    output req_ready, resp_valid, resp_data, mul_a, mul_b, mul_en
  );

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready, mul_p,
    input  req_ready, resp_valid, resp_data, mul_a, mul_b, mul_en
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
//   Sequencer for a 32x32 multiply. It uses one external registered 16x16
//   unsigned multiplier cell. Four partial products are issued on
//   consecutive cycles. Each partial is accumulated into a 64-bit sum when
//   its tag leaves a MUL_LATENCY-deep tag pipe. The result is then
//   corrected for signed high-word variants and returned over a
//   valid/ready response.
//
//   Parameters:
//     MUL_LATENCY : clock edges from mul_a/mul_b (with mul_en) to mul_p, 1..3
//
//   Ports:
//     clk     : single clock, rising edge
//     reset_n : synchronous active-low reset
//     bus     : request/response handshakes and multiplier cell (slave)
//     state_o : current FSM state, for debug
//
//   req_op encoding: 00 MUL (low word), 01 MULXUU, 10 MULXSS, 11 MULXSU.
module mul_seq_ctrl #(
  parameter int MUL_LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  mul_seq_ctrl_if.slave bus,
  output logic [2:0]    state_o
);

  localparam int L = MUL_LATENCY;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_FIX   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXUU = 2'b01;
  localparam logic [1:0] OP_MULXSS = 2'b10;
  localparam logic [1:0] OP_MULXSU = 2'b11;

  // Shift codes carried in the tag: 0 -> <<0, 1 -> <<16, 2 -> <<32.
  localparam logic [1:0] SH_0  = 2'd0;
  localparam logic [1:0] SH_16 = 2'd1;
  localparam logic [1:0] SH_32 = 2'd2;

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [15:0] mul_a_q, mul_a_d;
  logic [15:0] mul_b_q, mul_b_d;
  logic        mul_en_q, mul_en_d;

  // Tag pipe: stage 0 is loaded on the edge where the cell samples an
  // operand pair. Stage L-1 lines up with that pair's product on mul_p.
  logic [L-1:0] tag_vld_q;
  logic [1:0]   tag_sh_q [L];

  logic        tag_in_vld;
  logic [1:0]  tag_in_sh;
  logic        cap_vld;
  logic [1:0]  cap_sh;
  logic [63:0] partial;
  logic        early_busy;
  logic [31:0] hi_word;
  logic [31:0] corr_a;
  logic [31:0] corr_b;
  logic [31:0] fix_result;

  // A partial is issued in every ISSUE cycle. The cell sees mul_a_q/mul_b_q
  // for index k_q during that cycle.
  always_comb begin
    tag_in_vld = (state_q == S_ISSUE);
    unique case (k_q)
      2'd0:    tag_in_sh = SH_0;
      2'd3:    tag_in_sh = SH_32;
      default: tag_in_sh = SH_16;
    endcase
  end

  assign cap_vld = tag_vld_q[L-1];
  assign cap_sh  = tag_sh_q[L-1];

  always_comb begin
    unique case (cap_sh)
      SH_16:   partial = {16'd0, bus.mul_p, 16'd0};
      SH_32:   partial = {bus.mul_p, 32'd0};
      default: partial = {32'd0, bus.mul_p};
    endcase
  end

  // DRAIN may leave once only the final stage can still hold a tag. That
  // tag is captured on the same edge as the move to FIX.
  always_comb begin
    early_busy = 1'b0;
    for (int i = 0; i < L - 1; i++) begin
      early_busy = early_busy | tag_vld_q[i];
    end
  end

  // Signed high-word correction. The signed product equals the unsigned
  // product minus 2^32 times each operand whose partner is negative.
  assign hi_word = acc_q[63:32];
  assign corr_a  = a_q[31] ? b_q : 32'd0;
  assign corr_b  = b_q[31] ? a_q : 32'd0;

  always_comb begin
    unique case (op_q)
      OP_MUL:    fix_result = acc_q[31:0];
      OP_MULXUU: fix_result = hi_word;
      OP_MULXSS: fix_result = hi_word - corr_a - corr_b;
      OP_MULXSU: fix_result = hi_word - corr_a;
      default:   fix_result = hi_word;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    acc_d       = acc_q;
    resp_data_d = resp_data_q;

    if (cap_vld) begin
      acc_d = acc_q + partial;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          op_d    = bus.req_op;
          acc_d   = 64'd0;
          k_d     = 2'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!early_busy) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        resp_data_d = fix_result;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered. They are derived from the state being
    // entered so that they line up with it.
    resp_valid_d = (state_d == S_RESP);
    mul_en_d     = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    mul_a_d      = 16'd0;
    mul_b_d      = 16'd0;
    if (state_d == S_ISSUE) begin
      unique case (k_d)
        2'd0: begin mul_a_d = a_d[15:0];  mul_b_d = b_d[15:0];  end
        2'd1: begin mul_a_d = a_d[15:0];  mul_b_d = b_d[31:16]; end
        2'd2: begin mul_a_d = a_d[31:16]; mul_b_d = b_d[15:0];  end
        default: begin mul_a_d = a_d[31:16]; mul_b_d = b_d[31:16]; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      k_q          <= 2'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      op_q         <= 2'd0;
      acc_q        <= 64'd0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'd0;
      mul_a_q      <= 16'd0;
      mul_b_q      <= 16'd0;
      mul_en_q     <= 1'b0;
      for (int i = 0; i < L; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_sh_q[i]  <= 2'd0;
      end
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      acc_q        <= acc_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      mul_en_q     <= mul_en_d;
      for (int i = L - 1; i > 0; i--) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_sh_q[i]  <= tag_sh_q[i-1];
      end
      tag_vld_q[0] <= tag_in_vld;
      tag_sh_q[0]  <= tag_in_sh;
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE) && reset_n;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.mul_en     = mul_en_q;
  assign state_o        = state_q;

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Multi-cycle sequencer for the CPU's 32x32 multiply. It schedules a single external registered 16x16 unsigned multiplier cell over four partial products and accumulates them into a 64-bit product. It then applies signed-high correction and returns one 32-bit result per request over a valid/ready handshake. It sits between the execute-stage custom-instruction issue logic and the dedicated multiplier block.

## Interface
- MUL_LATENCY, 1, clock edges from mul_a/mul_b (with mul_en) to mul_p; legal range 1..3

- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  reset; synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (IDLE only)
- req_op  in  2  00 MUL, 01 MULXUU, 10 MULXSS, 11 MULXSU
- req_a  in  32  operand A
- req_b  in  32  operand B
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_data  out  32  result
- mul_a  out  16  multiplier cell operand A
- mul_b  out  16  multiplier cell operand B
- mul_en  out  1  multiplier cell clock enable
- mul_p  in  32  multiplier cell unsigned product, MUL_LATENCY cycles after issue

## Operation
- States: IDLE, ISSUE, DRAIN, FIX, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch a, b, op; clear the 64-bit acc; go to ISSUE with k=0.
- ISSUE (4 cycles, k=0..3): drive one partial per cycle.
  - k0: a[15:0]*b[15:0], shift 0
  - k1: a[15:0]*b[31:16], shift 16
  - k2: a[31:16]*b[15:0], shift 16
  - k3: a[31:16]*b[31:16], shift 32
  - After k=3, go to DRAIN.
- A tag shift register of depth MUL_LATENCY carries {valid, shift} per issue. When a tag emerges, add zero-extended (mul_p << shift) to acc, modulo 2^64.
- mul_en=1 in ISSUE and DRAIN, 0 otherwise. The cell holds when mul_en=0.
- DRAIN: wait until the last tag has been captured, then go to FIX.
- FIX: compute the result into resp_data, all modulo 2^32.
  - MUL: acc[31:0]
  - MULXUU: acc[63:32]
  - MULXSS: acc[63:32] - (a[31]?b:0) - (b[31]?a:0)
  - MULXSU: acc[63:32] - (a[31]?b:0)
  - Go to RESP.
- RESP: resp_valid=1 and resp_data stable until resp_ready. On handshake go to IDLE.
- mul_a/mul_b are 0 outside ISSUE.
- Reset (reset_n low at an edge), including mid-operation:
  - state=IDLE, acc=0, tags cleared, resp_valid=0, resp_data=0, mul_a=mul_b=0, mul_en=0.
  - req_ready=0 while reset_n=0.
  - An aborted operation produces no response. Products still in flight in the cell are ignored because their tags are cleared.
- req_valid outside IDLE is ignored; no queueing.
- Operands are not re-sampled after acceptance. Changing req_a/req_b after the handshake has no effect.

## Timing
- Cycle 0: accept. Cycles 1..4: issue k0..k3.
- Partial k is captured at the end of cycle 1+k+MUL_LATENCY.
- FIX runs in cycle 5+MUL_LATENCY.
- resp_valid first asserts in cycle 6+MUL_LATENCY: 7 cycles for MUL_LATENCY=1.
- Earliest next accept is the cycle after the resp handshake.
- Throughput with resp_ready held high: one op per 7+MUL_LATENCY cycles.
- All outputs are registered except req_ready = (state==IDLE) & reset_n.

## Test plan
- MUL a=0x00001234, b=0x00005678 (MUL_LATENCY=1) -> resp_data=0x06260060, resp_valid rises exactly 7 cycles after accept.
- MULXUU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MUL with the same operands -> 0x00000001.
- MULXSS a=b=0xFFFFFFFF -> 0x00000000. MULXSU a=0xFFFFFFFF, b=0x00000002 -> 0xFFFFFFFF. MULXSS a=0x80000000, b=0x80000000 -> 0x40000000.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_data stable, req_ready=0, and a req_valid pulse is not accepted. Release resp_ready -> req_ready=1 the next cycle.
- Reset pulse in ISSUE cycle k=2 -> no resp_valid ever. req_ready=1 the first cycle reset_n is high. The next MULXUU a=0x00010000, b=0x00010000 returns 0x00000001, uncorrupted by in-flight partials.
- MUL_LATENCY=3, MUL a=0x0000FFFF, b=0x0000FFFF -> 0xFFFE0001, resp_valid 9 cycles after accept. mul_en stays high continuously from cycle 1 through the last capture.
